// File: rtl/fifo_pkt_framer.sv
// Drains a byte FIFO and emits framed packets (sync, length, payload, checksum)
// on a valid/ready byte stream; short frames are flushed after an idle timeout.
module fifo_pkt_framer #(
    parameter int              DATA_W    = 8,
    parameter int              CNT_W     = 4,
    parameter int              FRAME_LEN = 8,
    parameter int              TIMEOUT   = 64,
    parameter logic [DATA_W-1:0] SYNC    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_read,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [2:0] {IDLE, HDR, LEN, RD, WT, PAY, CHK} state_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);
    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [15:0]       timer;
    logic [DATA_W-1:0] len;
    logic [DATA_W-1:0] remaining;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] byte_q;
    logic              full_ready;
    logic              partial;

    assign full_ready = (fifo_count >= FULL_CNT);
    assign partial    = !fifo_empty && (fifo_count < FULL_CNT);

    always_comb begin
        state_nxt = state;
        fifo_read = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (full_ready)
                    state_nxt = HDR;
                else if (partial && timer == TMO_LAST)
                    state_nxt = HDR;
            end
            HDR: begin
                m_valid = 1'b1;
                m_data  = SYNC;
                if (m_ready) state_nxt = LEN;
            end
            LEN: begin
                m_valid = 1'b1;
                m_data  = len;
                if (m_ready) state_nxt = RD;
            end
            RD: begin
                // Sole reader, so an empty FIFO here only stalls rather than errors.
                if (!fifo_empty) begin
                    fifo_read = 1'b1;
                    state_nxt = WT;
                end
            end
            WT: state_nxt = PAY;
            PAY: begin
                m_valid = 1'b1;
                m_data  = byte_q;
                if (m_ready) state_nxt = (remaining == DATA_W'(1)) ? CHK : RD;
            end
            CHK: begin
                m_valid = 1'b1;
                m_data  = sum;
                if (m_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            len        <= '0;
            remaining  <= '0;
            sum        <= '0;
            byte_q     <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= (state == CHK) && m_ready;
            case (state)
                IDLE: begin
                    // A full frame wins over a pending timeout flush.
                    if (full_ready) begin
                        len       <= DATA_W'(FRAME_LEN);
                        remaining <= DATA_W'(FRAME_LEN);
                        sum       <= '0;
                        timer     <= '0;
                    end else if (partial) begin
                        if (timer == TMO_LAST) begin
                            len       <= DATA_W'(fifo_count);
                            remaining <= DATA_W'(fifo_count);
                            sum       <= '0;
                            timer     <= '0;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end else begin
                        timer <= '0;
                    end
                end
                LEN: if (m_ready) sum <= len;
                WT:  byte_q <= fifo_data;
                PAY: begin
                    if (m_ready) begin
                        sum       <= sum + byte_q;
                        remaining <= remaining - DATA_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Self-checking bench for fifo_pkt_framer: a behavioural FIFO feeds the DUT and
// a negedge monitor pops hand-computed expected stream bytes from a scoreboard.
`timescale 1ns/1ps
module tb_fifo_pkt_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty;
    logic [3:0] fifo_count;
    logic [7:0] fifo_data;
    logic       fifo_read;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       busy;
    logic       frame_done;

    int checks_total  = 0;
    int checks_passed = 0;
    int rd_cnt        = 0;
    int frame_cnt     = 0;
    bit sb_en         = 1'b1;
    bit rand_mode     = 1'b0;
    logic [7:0] exp_q[$];

    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] fifo_mem [16];
    logic [7:0] fifo_dout = 8'h00;
    int wp = 0, rp = 0, occ = 0;

    always #5 clk = ~clk;

    // Behavioural 16-deep FIFO with a registered read port
    always @(posedge clk) begin
        if (fifo_read && occ > 0) begin
            fifo_dout <= fifo_mem[rp];
            rp        <= (rp + 1) % 16;
        end
        if (wr_en) begin
            fifo_mem[wp] <= wr_data;
            wp           <= (wp + 1) % 16;
        end
        occ <= occ + (wr_en ? 1 : 0) - ((fifo_read && occ > 0) ? 1 : 0);
    end

    assign fifo_empty = (occ == 0);
    assign fifo_count = 4'(occ);
    assign fifo_data  = fifo_dout;

    always @(posedge clk) begin
        #1;
        m_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    fifo_pkt_framer #(
        .DATA_W(8), .CNT_W(4), .FRAME_LEN(8), .TIMEOUT(64), .SYNC(8'hA5)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_empty(fifo_empty), .fifo_count(fifo_count), .fifo_data(fifo_data),
        .fifo_read(fifo_read),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .frame_done(frame_done)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checks_total++;
        if (act == exp) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk); #1;
        wr_en   = 1'b1;
        wr_data = b;
    endtask

    task automatic stopWrite();
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n = 0;
        while (frame_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checkOutput("frames_done", frame_cnt, target);
    endtask

    task automatic pushFrame(input logic [7:0] first, input int len, input logic [7:0] step,
                             input logic [7:0] chk);
        logic [7:0] b;
        b = first;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(b);
            b = b + step;
        end
        exp_q.push_back(chk);
    endtask

    // Scoreboard monitor plus handshake-stability and read-placement checks
    logic       hold_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_read) begin
                rd_cnt++;
                checkOutput("read_while_valid", m_valid, 0);
            end
            if (frame_done) frame_cnt++;
            if (hold_prev) begin
                checkOutput("hold_valid", m_valid, 1);
                checkOutput("hold_data", m_data, data_prev);
            end
            if (sb_en && m_valid && m_ready) begin
                if (exp_q.size() == 0) checkOutput("stream_extra_byte", m_data, -1);
                else checkOutput("stream_byte", m_data, exp_q.pop_front());
            end
            hold_prev = m_valid && !m_ready;
            data_prev = m_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        int f0, r0, n, seen;
        longint t_write;

        repeat (3) @(negedge clk);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_fifo_read", fifo_read, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_m_data", m_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] full frame 01..08");
        f0 = frame_cnt; r0 = rd_cnt;
        pushFrame(8'h01, 8, 8'h01, 8'h2C);
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
        stopWrite();
        waitFrames(f0 + 1, 200);
        checkOutput("t1_reads", rd_cnt - r0, 8);
        checkOutput("t1_queue_left", exp_q.size(), 0);

        $display("[TB] timeout flush 10,20,30");
        f0 = frame_cnt; r0 = rd_cnt;
        pushFrame(8'h10, 3, 8'h10, 8'h63);
        applyStimulus(8'h10);
        t_write = $time;
        applyStimulus(8'h20);
        applyStimulus(8'h30);
        stopWrite();
        n = 0;
        while (!m_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t2_flush_latency", int'($time - t_write), 654);
        waitFrames(f0 + 1, 200);
        checkOutput("t2_reads", rd_cnt - r0, 3);
        checkOutput("t2_queue_left", exp_q.size(), 0);

        $display("[TB] full frame with random backpressure");
        rand_mode = 1'b1;
        f0 = frame_cnt; r0 = rd_cnt;
        pushFrame(8'h01, 8, 8'h01, 8'h2C);
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
        stopWrite();
        waitFrames(f0 + 1, 600);
        checkOutput("t3_reads", rd_cnt - r0, 8);
        checkOutput("t3_queue_left", exp_q.size(), 0);
        rand_mode = 1'b0;

        $display("[TB] twelve bytes: full frame then timeout frame");
        f0 = frame_cnt; r0 = rd_cnt;
        pushFrame(8'h01, 8, 8'h01, 8'h2C);
        pushFrame(8'h09, 4, 8'h01, 8'h2E);
        for (int i = 1; i <= 12; i++) applyStimulus(8'(i));
        stopWrite();
        waitFrames(f0 + 2, 600);
        checkOutput("t4_reads", rd_cnt - r0, 12);
        checkOutput("t4_queue_left", exp_q.size(), 0);

        $display("[TB] checksum wrap with 0xFF payload");
        f0 = frame_cnt; r0 = rd_cnt;
        pushFrame(8'hFF, 8, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) applyStimulus(8'hFF);
        stopWrite();
        waitFrames(f0 + 1, 200);
        checkOutput("t5_reads", rd_cnt - r0, 8);
        checkOutput("t5_queue_left", exp_q.size(), 0);

        $display("[TB] reset during payload");
        sb_en = 1'b0;
        f0 = frame_cnt;
        for (int i = 0; i < 8; i++) applyStimulus(8'h41 + 8'(i));
        stopWrite();
        seen = 0; n = 0;
        while (seen < 3 && n < 300) begin
            @(negedge clk);
            if (fifo_read) seen++;
            n++;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!m_valid && n < 300);
        checkOutput("t6_busy_before", busy, 1);
        checkOutput("t6_valid_before", m_valid, 1);
        rst = 1'b1;
        #1;
        checkOutput("t6_async_m_valid", m_valid, 0);
        checkOutput("t6_async_fifo_read", fifo_read, 0);
        checkOutput("t6_async_busy", busy, 0);
        checkOutput("t6_async_m_data", m_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("t6_no_frame_done", frame_cnt - f0, 0);
        r0 = rd_cnt;
        sb_en = 1'b1;
        pushFrame(8'h44, 5, 8'h01, 8'h63);
        waitFrames(f0 + 1, 300);
        checkOutput("t6_reads", rd_cnt - r0, 5);
        checkOutput("t6_queue_left", exp_q.size(), 0);
        checkOutput("t6_fifo_drained", occ, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
